button_debounce: RTL and testbench

Input-side counterpart to the board LED drivers. It samples one raw, asynchronous push-button pin, synchronizes it, and debounces it. It produces a clean level plus single-cycle press, release and long-press event pulses for downstream control logic such as LED mode selection.
One instance per button. All logic runs in the single fabric clock domain.

---
 rtl/button_debounce.sv | 200 ++++++++++++++++++++
 tb/tb_button_debounce.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer plus debounce FSM for one push-button pin.
// Produces a clean level and single-cycle press, release, long-press and repeat pulses.
//
// Ports:
//   clk         fabric clock
//   rstn        asynchronous active-low reset
//   btn_in      raw button pin, asynchronous to clk
//   btn_level   debounced state, 1 = pressed
//   btn_press   one-cycle pulse on accepted press
//   btn_release one-cycle pulse on accepted release
//   btn_long    one-cycle pulse once per press when the hold reaches LONG_CYCLES
//   btn_repeat  auto-repeat pulse after btn_long
//
// Optional feature: define BTN_REPEAT_EN to build the auto-repeat counter.
// Without it btn_repeat is tied to 0.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CNT_WIDTH       = 27,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_repeat
);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES ||
        REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_debounce: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    localparam logic INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0] DEB = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LNG = CNT_WIDTH'(LONG_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic sync1;
    logic sync2;
    logic pressed_s;

    state_t state;
    state_t state_nx;
    logic [CNT_WIDTH-1:0] dcnt;
    logic [CNT_WIDTH-1:0] dcnt_nx;
    logic [CNT_WIDTH-1:0] hcnt;
    logic [CNT_WIDTH-1:0] hcnt_nx;
    logic level_nx;
    logic press_nx;
    logic release_nx;
    logic long_nx;
    logic hold_run;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign pressed_s = sync2 ^ INACTIVE;

    always_comb begin
        state_nx   = state;
        dcnt_nx    = dcnt;
        hcnt_nx    = hcnt;
        level_nx   = btn_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        hold_run   = 1'b0;
        unique case (state)
            IDLE: begin
                level_nx = 1'b0;
                if (pressed_s) begin
                    state_nx = PRESS_CHK;
                    dcnt_nx  = ONE;
                end
            end
            PRESS_CHK: begin
                if (!pressed_s) begin
                    state_nx = IDLE;
                    dcnt_nx  = '0;
                end else if (dcnt == DEB) begin
                    state_nx = HELD;
                    press_nx = 1'b1;
                    level_nx = 1'b1;
                    dcnt_nx  = '0;
                    hcnt_nx  = '0;
                end else begin
                    dcnt_nx = dcnt + ONE;
                end
            end
            HELD: begin
                hold_run = 1'b1;
                if (!pressed_s) begin
                    state_nx = RELEASE_CHK;
                    dcnt_nx  = ONE;
                end
            end
            RELEASE_CHK: begin
                hold_run = 1'b1;
                if (pressed_s) begin
                    state_nx = HELD;
                    dcnt_nx  = '0;
                end else if (dcnt == DEB) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                    level_nx   = 1'b0;
                    dcnt_nx    = '0;
                    hcnt_nx    = '0;
                end else begin
                    dcnt_nx = dcnt + ONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Hold timer runs through release glitches; an accepted release
        // clears it and suppresses any long pulse due in the same cycle.
        if (hold_run && state_nx != IDLE && hcnt != LNG) begin
            hcnt_nx = hcnt + ONE;
            long_nx = (hcnt_nx == LNG);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            state       <= state_nx;
            dcnt        <= dcnt_nx;
            hcnt        <= hcnt_nx;
            btn_level   <= level_nx;
            btn_press   <= press_nx;
            btn_release <= release_nx;
            btn_long    <= long_nx;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REP_M1 = CNT_WIDTH'(REPEAT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] rcnt;
    logic [CNT_WIDTH-1:0] rcnt_nx;
    logic repeat_nx;

    // Repeat period starts counting the cycle after btn_long, i.e. once
    // the hold timer sits saturated.
    always_comb begin
        rcnt_nx   = rcnt;
        repeat_nx = 1'b0;
        if (state_nx == IDLE) begin
            rcnt_nx = '0;
        end else if (hold_run && hcnt == LNG) begin
            if (rcnt == REP_M1) begin
                rcnt_nx   = '0;
                repeat_nx = 1'b1;
            end else begin
                rcnt_nx = rcnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcnt       <= '0;
            btn_repeat <= 1'b0;
        end else begin
            rcnt       <= rcnt_nx;
            btn_repeat <= repeat_nx;
        end
    end
`else
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed, table-driven checks of button_debounce
// with DEBOUNCE=4, LONG=20, REPEAT=8, active-low pin.
module tb_button_debounce;

    logic clk;
    logic rstn;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;
    logic btn_repeat;

    int checks;
    int errors;

    typedef struct {
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[64];
    int   ntbl;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(8),
        .CNT_WIDTH(8),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long),
        .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {btn_level, btn_press, btn_release, btn_long, btn_repeat};
    endfunction

    function automatic logic [4:0] mk(logic lv, logic pr, logic rl,
                                      logic lg, logic rp);
        return {lv, pr, rl, lg, rp};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got lvl/prs/rel/lng/rep=%b expected %b",
                     name, act, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic b, input logic [4:0] e);
        tbl[ntbl].btn = b;
        tbl[ntbl].exp = e;
        ntbl++;
    endtask

    task automatic press_seq(input string name);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0);
            check(name, mk(k == 7, k == 7, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic release_seq(input string name, input int rep_at);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            check(name, mk(k < 7, 1'b0, k == 7, 1'b0, k == rep_at));
        end
    endtask

    initial begin
        logic b;
        logic rep;
        checks = 0;
        errors = 0;
        ntbl   = 0;
        rstn   = 1'b0;
        btn_in = 1'b1;

        // bounce: low 3, high 1, low 2, then high
        for (int k = 0; k < 12; k++) begin
            b = !(k < 3 || k == 4 || k == 5);
            add(b, 5'b0);
        end
        for (int k = 1; k <= 10; k++)
            add(1'b0, mk(k >= 7, k == 7, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 10; k++)
            add(1'b1, mk(k < 7, 1'b0, k == 7, 1'b0, 1'b0));

        // reset with a toggling pin
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            btn_in = k[0];
            @(posedge clk);
            #1;
            check("reset_hold", 5'b0);
        end
        @(negedge clk);
        btn_in = 1'b1;
        rstn   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step(1'b1);
            check("post_reset_idle", 5'b0);
        end

        // bounce, clean press and clean release
        for (int i = 0; i < ntbl; i++) begin
            step(tbl[i].btn);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // long press with a 2-cycle glitch at hold cycle 10
        press_seq("long_press");
        for (int k = 1; k <= 50; k++) begin
            b = (k == 10 || k == 11);
`ifdef BTN_REPEAT_EN
            rep = (k == 28 || k == 36 || k == 44);
`else
            rep = 1'b0;
`endif
            step(b);
            check($sformatf("long_hold[%0d]", k),
                  mk(1'b1, 1'b0, 1'b0, k == 20, rep));
        end
`ifdef BTN_REPEAT_EN
        release_seq("long_release", 2);
`else
        release_seq("long_release", 0);
`endif

        // reset mid-hold with the button still down
        press_seq("mid_press");
        for (int k = 1; k <= 4; k++) begin
            step(1'b0);
            check("mid_hold", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_reset_async", 5'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("mid_reset_hold", 5'b0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_after_edge1", 5'b0);
        for (int k = 2; k <= 10; k++) begin
            step(1'b0);
            check($sformatf("mid_repress[%0d]", k),
                  mk(k >= 7, k == 7, 1'b0, 1'b0, 1'b0));
        end
        release_seq("mid_release", 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
